// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan counter: digit width,
// active-high glyph table and the per-digit maximum helper.
package seg7_pkg;

  localparam int DIGIT_W = 4;

  // Index 0 is the rightmost element; bit0=a .. bit6=g.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [DIGIT_W-1:0] digit_max(input logic bcd);
    return bcd ? 4'd9 : 4'hF;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational 4-bit digit to active-high seven-segment glyph decoder.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         glyph
);

  assign glyph = GLYPH_TABLE[digit];

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit hex/BCD up/down counter with prescaled stepping and a
// multiplexed seven-segment display scanner.
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10000000,
  parameter int SCAN_DIV   = 1000,
  parameter int BCD        = 0,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          dir,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
  output logic [DIGIT_W*NUM_DIGITS-1:0] value,
  output logic [6:0]                    segments,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          tick,
  output logic                          wrap
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]   PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIGIT_W-1:0] DMAX     = digit_max(BCD != 0);

  logic [PRE_W-1:0]                prescale;
  logic [SCAN_W-1:0]               scan_cnt;
  logic [IDX_W-1:0]                digit_idx;
  logic [DIGIT_W*NUM_DIGITS-1:0]   stepped;
  logic [DIGIT_W*NUM_DIGITS-1:0]   loaded;
  logic                            step_carry;
  logic [DIGIT_W-1:0]              cur_digit;
  logic [6:0]                      glyph;
  logic [NUM_DIGITS-1:0]           sel_onehot;

  // Ripple the +1/-1 through the digits; a carry surviving the top digit is a rollover.
  always_comb begin
    stepped    = value;
    step_carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (step_carry) begin
        if (dir) begin
          if (value[i*DIGIT_W +: DIGIT_W] == DMAX) begin
            stepped[i*DIGIT_W +: DIGIT_W] = '0;
          end else begin
            stepped[i*DIGIT_W +: DIGIT_W] = value[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
            step_carry = 1'b0;
          end
        end else begin
          if (value[i*DIGIT_W +: DIGIT_W] == '0) begin
            stepped[i*DIGIT_W +: DIGIT_W] = DMAX;
          end else begin
            stepped[i*DIGIT_W +: DIGIT_W] = value[i*DIGIT_W +: DIGIT_W] - DIGIT_W'(1);
            step_carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    loaded = load_data;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_data[i*DIGIT_W +: DIGIT_W] > DMAX) begin
        loaded[i*DIGIT_W +: DIGIT_W] = DMAX;
      end
    end
  end

  // Load wins over a coincident step and restarts the prescaler phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale <= '0;
      value    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        value    <= loaded;
        prescale <= '0;
      end else if (en) begin
        if (prescale == PRE_MAX) begin
          prescale <= '0;
          value    <= stepped;
          tick     <= 1'b1;
          wrap     <= step_carry;
        end else begin
          prescale <= prescale + PRE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_comb begin
    cur_digit  = value[DIGIT_W-1:0];
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_digit     = value[i*DIGIT_W +: DIGIT_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  seg7_glyph_rom u_glyph (
    .digit (cur_digit),
    .glyph (glyph)
  );

  assign segments  = (ACTIVE_LOW != 0) ? ~glyph      : glyph;
  assign digit_sel = (ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Self-checking bench: hex, BCD and active-low instances driven in parallel
// and compared against an integer-arithmetic reference model.
module tb_seg7_scan_counter;

  localparam int ND = 4;
  localparam int TD = 4;
  localparam int SD = 2;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic dir = 1'b1;
  logic load = 1'b0;
  logic [15:0] load_data = 16'h0000;

  logic [15:0] h_value, b_value, a_value;
  logic [6:0]  h_seg, b_seg, a_seg;
  logic [3:0]  h_sel, b_sel, a_sel;
  logic        h_tick, b_tick, a_tick, h_wrap, b_wrap, a_wrap;

  int checks = 0;
  int passes = 0;

  int m_hex, m_bcd, phase, scan_n;
  bit e_tick, e_wrap_h, e_wrap_b;

  seg7_scan_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .BCD(0), .ACTIVE_LOW(0)) dut_hex (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_data(load_data),
    .value(h_value), .segments(h_seg), .digit_sel(h_sel), .tick(h_tick), .wrap(h_wrap));

  seg7_scan_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .BCD(1), .ACTIVE_LOW(0)) dut_bcd (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_data(load_data),
    .value(b_value), .segments(b_seg), .digit_sel(b_sel), .tick(b_tick), .wrap(b_wrap));

  seg7_scan_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .BCD(0), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_data(load_data),
    .value(a_value), .segments(a_seg), .digit_sel(a_sel), .tick(a_tick), .wrap(a_wrap));

  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Decimal interpretation of a load word with each nibble clamped to 9.
  function automatic int bcd_load(input logic [15:0] d);
    int r, n;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      n = int'((d >> (4*i)) & 16'h000F);
      if (n > 9) n = 9;
      r = r + n * pow10(i);
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int m);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((m / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int exp_idx();
    return (scan_n / SD) % ND;
  endfunction

  function automatic logic [6:0] hex_seg();
    return GLYPH[4'((m_hex >> (4*exp_idx())) & 15)];
  endfunction

  function automatic logic [6:0] bcd_seg();
    return GLYPH[4'((m_bcd / pow10(exp_idx())) % 10)];
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_hex = 0; m_bcd = 0; phase = 0; scan_n = 0;
      e_tick = 0; e_wrap_h = 0; e_wrap_b = 0;
    end else begin
      scan_n++;
      e_tick = 0; e_wrap_h = 0; e_wrap_b = 0;
      if (load) begin
        m_hex = int'(load_data); m_bcd = bcd_load(load_data); phase = 0;
      end else if (en) begin
        phase++;
        if (phase == TD) begin
          phase = 0; e_tick = 1;
          if (dir) begin
            e_wrap_h = (m_hex == 65535); m_hex = (m_hex + 1) % 65536;
            e_wrap_b = (m_bcd == 9999);  m_bcd = (m_bcd + 1) % 10000;
          end else begin
            e_wrap_h = (m_hex == 0); m_hex = (m_hex + 65535) % 65536;
            e_wrap_b = (m_bcd == 0); m_bcd = (m_bcd + 9999) % 10000;
          end
        end
      end
    end
  endtask

  task automatic tick_clock();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; load = 1'b1; load_data = 16'h5A5A;
    repeat (3) tick_clock();
    checks++; if (h_value !== 16'h0000) $display("[TB] FAIL reset_value got=%h exp=0000", h_value); else passes++;
    checks++; if (b_value !== 16'h0000) $display("[TB] FAIL reset_bcd_value got=%h exp=0000", b_value); else passes++;
    checks++; if (h_tick !== 1'b0 || h_wrap !== 1'b0) $display("[TB] FAIL reset_tick_wrap got=%b%b exp=00", h_tick, h_wrap); else passes++;
    checks++; if (h_sel !== 4'b0001) $display("[TB] FAIL reset_sel got=%b exp=0001", h_sel); else passes++;
    checks++; if (h_seg !== 7'h3F) $display("[TB] FAIL reset_seg got=%h exp=3F", h_seg); else passes++;
    checks++; if (a_sel !== 4'b1110 || a_seg !== 7'h40) $display("[TB] FAIL reset_active_low got=%b/%h exp=1110/40", a_sel, a_seg); else passes++;
    rst_n = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_count_up();
    int ticks;
    ticks = 0;
    en = 1'b1; dir = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick_clock();
      if (h_tick === 1'b1) ticks++;
      checks++; if (h_tick !== ((c % 4) == 3)) $display("[TB] FAIL count_up_tick cycle=%0d got=%b exp=%b", c, h_tick, ((c % 4) == 3)); else passes++;
    end
    checks++; if (h_value !== 16'h0004) $display("[TB] FAIL count_up_value got=%h exp=0004", h_value); else passes++;
    checks++; if (ticks != 4) $display("[TB] FAIL count_up_ticks got=%0d exp=4", ticks); else passes++;
    en = 1'b0;
  endtask

  task automatic test_bcd_carry();
    en = 1'b0; load = 1'b1; load_data = 16'h0099;
    tick_clock();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    repeat (4) tick_clock();
    checks++; if (b_value !== 16'h0100 || b_tick !== 1'b1) $display("[TB] FAIL bcd_carry got=%h/%b exp=0100/1", b_value, b_tick); else passes++;
    en = 1'b0; load = 1'b1; load_data = 16'hFFFF;
    tick_clock();
    load = 1'b0;
    checks++; if (b_value !== 16'h9999) $display("[TB] FAIL bcd_clamp got=%h exp=9999", b_value); else passes++;
    en = 1'b1;
    repeat (4) tick_clock();
    checks++; if (b_value !== 16'h0000 || b_wrap !== 1'b1) $display("[TB] FAIL bcd_rollover got=%h/%b exp=0000/1", b_value, b_wrap); else passes++;
    tick_clock();
    checks++; if (b_wrap !== 1'b0 || b_tick !== 1'b0) $display("[TB] FAIL bcd_wrap_pulse got=%b%b exp=00", b_wrap, b_tick); else passes++;
    en = 1'b0;
  endtask

  task automatic test_hex_borrow();
    load = 1'b1; load_data = 16'h0000;
    tick_clock();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    repeat (4) tick_clock();
    checks++; if (h_value !== 16'hFFFF || h_tick !== 1'b1 || h_wrap !== 1'b1) $display("[TB] FAIL hex_borrow got=%h/%b%b exp=FFFF/11", h_value, h_tick, h_wrap); else passes++;
    checks++; if (b_value !== 16'h9999 || b_wrap !== 1'b1) $display("[TB] FAIL bcd_borrow got=%h/%b exp=9999/1", b_value, b_wrap); else passes++;
    en = 1'b0; dir = 1'b1;
  endtask

  task automatic test_load_priority();
    int first_tick;
    first_tick = -1;
    load = 1'b1; load_data = 16'h0010;
    tick_clock();
    load = 1'b0; en = 1'b1;
    repeat (3) tick_clock();
    load = 1'b1; load_data = 16'hABCD;
    tick_clock();
    load = 1'b0;
    checks++; if (h_value !== 16'hABCD || h_tick !== 1'b0) $display("[TB] FAIL load_priority got=%h/%b exp=ABCD/0", h_value, h_tick); else passes++;
    for (int c = 1; c <= 8; c++) begin
      tick_clock();
      if (h_tick === 1'b1 && first_tick < 0) first_tick = c;
    end
    checks++; if (first_tick != 4) $display("[TB] FAIL load_next_tick got=%0d exp=4", first_tick); else passes++;
    en = 1'b0;
  endtask

  task automatic test_scan();
    logic [6:0] es;
    logic [3:0] el;
    load = 1'b1; load_data = 16'h1234; en = 1'b0;
    tick_clock();
    load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick_clock();
      es = hex_seg();
      el = 4'(1 << exp_idx());
      checks++; if (h_sel !== el || h_seg !== es) $display("[TB] FAIL scan_cycle%0d got=%b/%h exp=%b/%h", c, h_sel, h_seg, el, es); else passes++;
      checks++; if (a_sel !== ~el || a_seg !== ~es) $display("[TB] FAIL scan_al_cycle%0d got=%b/%h exp=%b/%h", c, a_sel, a_seg, ~el, ~es); else passes++;
    end
  endtask

  task automatic test_random();
    logic [15:0] eh, eb;
    logic [6:0]  sh, sb;
    logic [3:0]  el;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(63) != 0);
      en = ($urandom_range(3) != 0);
      dir = 1'($urandom_range(1));
      load = ($urandom_range(15) == 0);
      load_data = 16'($urandom);
      tick_clock();
      eh = 16'(m_hex); eb = to_bcd(m_bcd); sh = hex_seg(); sb = bcd_seg(); el = 4'(1 << exp_idx());
      checks++; if (h_value !== eh) $display("[TB] FAIL rnd_hex_value c=%0d got=%h exp=%h", c, h_value, eh); else passes++;
      checks++; if (b_value !== eb) $display("[TB] FAIL rnd_bcd_value c=%0d got=%h exp=%h", c, b_value, eb); else passes++;
      checks++; if (a_value !== eh) $display("[TB] FAIL rnd_al_value c=%0d got=%h exp=%h", c, a_value, eh); else passes++;
      checks++; if (h_tick !== e_tick || b_tick !== e_tick) $display("[TB] FAIL rnd_tick c=%0d got=%b%b exp=%b", c, h_tick, b_tick, e_tick); else passes++;
      checks++; if (h_wrap !== e_wrap_h) $display("[TB] FAIL rnd_hex_wrap c=%0d got=%b exp=%b", c, h_wrap, e_wrap_h); else passes++;
      checks++; if (b_wrap !== e_wrap_b) $display("[TB] FAIL rnd_bcd_wrap c=%0d got=%b exp=%b", c, b_wrap, e_wrap_b); else passes++;
      checks++; if (h_sel !== el || h_seg !== sh) $display("[TB] FAIL rnd_hex_disp c=%0d got=%b/%h exp=%b/%h", c, h_sel, h_seg, el, sh); else passes++;
      checks++; if (b_sel !== el || b_seg !== sb) $display("[TB] FAIL rnd_bcd_disp c=%0d got=%b/%h exp=%b/%h", c, b_sel, b_seg, el, sb); else passes++;
      checks++; if (a_sel !== ~el || a_seg !== ~sh) $display("[TB] FAIL rnd_al_disp c=%0d got=%b/%h exp=%b/%h", c, a_sel, a_seg, ~el, ~sh); else passes++;
    end
    rst_n = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_bcd_carry();
    test_hex_borrow();
    test_load_priority();
    test_scan();
    test_random();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
